switch_oq_rd: RTL and testbench

Per-port output dequeue engine directly downstream of the port queue controller. It pops cell pointers from the controller's first-word-fall-through pointer FIFO and reads each cell's words from the shared cell data SRAM. It streams those words into the output MAC FIFO with frame delimiters, then returns each consumed pointer to the free-pointer manager.

---
 rtl/switch_oq_rd.sv | 172 +++++++++++++++++
 tb/tb_switch_oq_rd.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_oq_rd.sv
// switch_oq_rd -- per-port output dequeue engine.
//
// Pops cell pointers from the port queue controller's FWFT pointer FIFO,
// reads every word of each cell from the shared cell data SRAM, and streams
// the words into the output MAC FIFO with frame delimiters. Once the last
// word of a cell has left the read pipeline, the pointer is returned to the
// free-pointer manager. Cells are processed strictly one at a time.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   ptr_rdy       pointer available (ptr_dout valid while high)
//   ptr_dout      [15] last cell of frame, [PTR_AW-1:0] cell index
//   ptr_ack       one-cycle pop strobe to the queue controller
//   dmem_addr     SRAM read address {cell index, word index}
//   dmem_rd       SRAM read enable
//   dmem_dout     SRAM read data, valid RD_LAT cycles after dmem_rd
//   o_data        output word
//   o_wr          output write strobe
//   o_sof, o_eof  frame delimiters, qualified by o_wr
//   o_afull       output FIFO cannot absorb more than the in-flight reads
//   free_ptr      returned pointer with bit 15 cleared
//   free_wr       free write strobe
//   free_full     free-pointer FIFO full
//   busy          engine is working on a cell
//
// Optional build macro SWITCH_OQ_STAT_EN adds stat_frames / stat_cells
// (frames written and cells freed, 32-bit wrapping counters).

module switch_oq_rd #(
  parameter int DATA_W     = 128,
  parameter int CELL_WORDS = 4,
  parameter int PTR_AW     = 10,
  parameter int RD_LAT     = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 ptr_rdy,
  input  logic [15:0]                          ptr_dout,
  output logic                                 ptr_ack,
  output logic [PTR_AW+$clog2(CELL_WORDS)-1:0] dmem_addr,
  output logic                                 dmem_rd,
  input  logic [DATA_W-1:0]                    dmem_dout,
  output logic [DATA_W-1:0]                    o_data,
  output logic                                 o_wr,
  output logic                                 o_sof,
  output logic                                 o_eof,
  input  logic                                 o_afull,
  output logic [15:0]                          free_ptr,
  output logic                                 free_wr,
  input  logic                                 free_full,
  output logic                                 busy
`ifdef SWITCH_OQ_STAT_EN
  ,
  output logic [31:0]                          stat_frames,
  output logic [31:0]                          stat_cells
`endif
);

  localparam int WIDX_W = $clog2(CELL_WORDS);
  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(CELL_WORDS - 1);
  // Every pipeline stage except the output stage. When none of those hold a
  // word, the final word is leaving this cycle and the pointer can be freed
  // next cycle.
  localparam logic [RD_LAT-1:0] EARLY_MASK = {RD_LAT{1'b1}} >> 1;

  typedef enum logic [2:0] {IDLE, POP, READ, DRAIN, FREE} state_t;

  state_t              state_q;
  state_t              state_d;
  logic [15:0]         cur_ptr;
  logic [WIDX_W-1:0]   word_idx;
  logic                sof_pend;
  logic [RD_LAT-1:0]   pipe_vld;
  logic [RD_LAT-1:0]   pipe_sof;
  logic [RD_LAT-1:0]   pipe_eof;
  logic                last_issue;

  assign last_issue = dmem_rd && (word_idx == LAST_WORD);

  // Next-state and strobe decode. The ack is also blocked while rst is
  // high: reset parks the FSM in IDLE, and without the gate the controller
  // would pop a pointer that the engine never latches.
  always_comb begin
    state_d = state_q;
    ptr_ack = 1'b0;
    dmem_rd = 1'b0;
    free_wr = 1'b0;
    case (state_q)
      IDLE: begin
        if (ptr_rdy && !rst) begin
          ptr_ack = 1'b1;
          state_d = POP;
        end
      end
      POP: state_d = READ;
      READ: begin
        dmem_rd = !o_afull;
        if (!o_afull && (word_idx == LAST_WORD)) state_d = DRAIN;
      end
      DRAIN: begin
        if ((pipe_vld & EARLY_MASK) == '0) state_d = FREE;
      end
      FREE: begin
        if (!free_full) begin
          free_wr = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus the per-cell context: latched pointer, word index
  // and the start-of-frame pending flag that carries across cells.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cur_ptr  <= '0;
      word_idx <= '0;
      sof_pend <= 1'b1;
    end else begin
      state_q <= state_d;
      if (ptr_ack) cur_ptr <= ptr_dout;
      if (state_q == POP) word_idx <= '0;
      else if (dmem_rd) word_idx <= word_idx + 1'b1;
      // With one-word cells sof and eof hit the same issue; setting wins.
      if (last_issue && cur_ptr[15]) sof_pend <= 1'b1;
      else if (dmem_rd && (word_idx == '0)) sof_pend <= 1'b0;
    end
  end

  // Read pipeline mirroring the SRAM latency: each issued read carries its
  // valid bit and frame flags so they emerge alongside dmem_dout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      pipe_sof <= '0;
      pipe_eof <= '0;
    end else begin
      pipe_vld[0] <= dmem_rd;
      pipe_sof[0] <= dmem_rd && (word_idx == '0) && sof_pend;
      pipe_eof[0] <= last_issue && cur_ptr[15];
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_sof[i] <= pipe_sof[i-1];
        pipe_eof[i] <= pipe_eof[i-1];
      end
    end
  end

  assign dmem_addr = {cur_ptr[PTR_AW-1:0], word_idx};
  assign o_wr      = pipe_vld[RD_LAT-1];
  assign o_sof     = pipe_sof[RD_LAT-1];
  assign o_eof     = pipe_eof[RD_LAT-1];
  assign o_data    = o_wr ? dmem_dout : '0;
  assign free_ptr  = free_wr ? {1'b0, cur_ptr[14:0]} : 16'h0000;
  assign busy      = (state_q != IDLE);

`ifdef SWITCH_OQ_STAT_EN
  // Frame and cell counters, free-running and wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_frames <= '0;
      stat_cells  <= '0;
    end else begin
      if (o_wr && o_eof) stat_frames <= stat_frames + 32'd1;
      if (free_wr) stat_cells <= stat_cells + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_switch_oq_rd.sv
// tb_switch_oq_rd -- bench for switch_oq_rd with its default parameters.
// A scoreboard derives every expected SRAM address, output word, delimiter
// and returned pointer from the popped pointers and checks the DUT each
// cycle; directed scenarios add hand-computed literal expectations.
// Also covers the SWITCH_OQ_STAT_EN counters when that macro is defined.

module tb_switch_oq_rd;

  localparam int DATA_W     = 128;
  localparam int CELL_WORDS = 4;
  localparam int PTR_AW     = 10;
  localparam int RD_LAT     = 2;
  localparam int WB         = $clog2(CELL_WORDS);
  localparam int AW         = PTR_AW + WB;

  logic              clk = 1'b0;
  logic              rst;
  logic              ptr_rdy;
  logic [15:0]       ptr_dout;
  logic              ptr_ack;
  logic [AW-1:0]     dmem_addr;
  logic              dmem_rd;
  logic [DATA_W-1:0] dmem_dout;
  logic [DATA_W-1:0] o_data;
  logic              o_wr, o_sof, o_eof, o_afull;
  logic [15:0]       free_ptr;
  logic              free_wr, free_full, busy;
`ifdef SWITCH_OQ_STAT_EN
  logic [31:0]       stat_frames, stat_cells;
`endif

  switch_oq_rd #(
    .DATA_W(DATA_W), .CELL_WORDS(CELL_WORDS), .PTR_AW(PTR_AW), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .ptr_rdy(ptr_rdy), .ptr_dout(ptr_dout),
    .ptr_ack(ptr_ack), .dmem_addr(dmem_addr), .dmem_rd(dmem_rd),
    .dmem_dout(dmem_dout), .o_data(o_data), .o_wr(o_wr), .o_sof(o_sof),
    .o_eof(o_eof), .o_afull(o_afull), .free_ptr(free_ptr),
    .free_wr(free_wr), .free_full(free_full), .busy(busy)
`ifdef SWITCH_OQ_STAT_EN
    , .stat_frames(stat_frames), .stat_cells(stat_cells)
`endif
  );

  always #5 clk = ~clk;

  // Cell SRAM contents: a distinct word per address.
  function automatic logic [DATA_W-1:0] memWord(input logic [AW-1:0] a);
    logic [DATA_W-1:0] w;
    for (int k = 0; k < DATA_W / 32; k++)
      w[k*32 +: 32] = 32'hA5C3_0000 ^ (32'(a) << 8) ^ 32'(k);
    return w;
  endfunction

  // Registered SRAM with fixed read latency.
  logic [DATA_W-1:0] memPipe [RD_LAT];
  always @(posedge clk) begin
    memPipe[0] <= dmem_rd ? memWord(dmem_addr) : '0;
    for (int i = 1; i < RD_LAT; i++) memPipe[i] <= memPipe[i-1];
  end
  assign dmem_dout = memPipe[RD_LAT-1];

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              sof;
    logic              eof;
  } exp_word_t;

  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;
  logic [15:0] ptrQ[$];
  logic        popReq = 1'b0;
  exp_word_t   expWord[$];
  logic [AW-1:0] expAddr[$];
  logic [15:0] freeQ[$];
  logic        sofPend = 1'b1;
  logic        rdHist[RD_LAT];
  int          expFrames = 0;
  int          expCells = 0;
  int          cellReads = 0;
  // per-scenario logs
  int          addrLog[$];
  int          freeLog[$];
  int          ackCycLog[$];
  int          freeCycLog[$];
  logic        wrSofLog[$];
  int          wrCnt, sofCnt, eofCnt;
  // back-pressure schedules
  logic        stallArm = 1'b0;
  int          afullLeft = 0;
  logic        fullArm = 1'b0;
  int          fullLeft = 0;

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic clearLogs();
    addrLog.delete(); freeLog.delete(); ackCycLog.delete();
    freeCycLog.delete(); wrSofLog.delete();
    wrCnt = 0; sofCnt = 0; eofCnt = 0;
  endtask

  // Per-cycle comparison against the scoreboard, sampled mid-cycle.
  task automatic compare();
    exp_word_t   e;
    logic [15:0] p;
    logic [AW-1:0] a;
    cycle++;
    if (rst) begin
      checkOutput("reset_strobes", {ptr_ack, dmem_rd, o_wr, o_sof, o_eof, free_wr, busy}, '0);
      checkOutput("reset_addr", dmem_addr, '0);
      checkOutput("reset_data", o_data, '0);
      checkOutput("reset_free_ptr", free_ptr, '0);
      expWord.delete(); expAddr.delete(); freeQ.delete();
      sofPend = 1'b1; popReq = 1'b0; expFrames = 0; expCells = 0;
      for (int i = 0; i < RD_LAT; i++) rdHist[i] = 1'b0;
      return;
    end
    checkOutput("busy", busy, freeQ.size() != 0);
    checkOutput("wr_latency", o_wr, rdHist[RD_LAT-1]);
    checkOutput("flag_without_wr", {o_sof, o_eof} & {2{~o_wr}}, '0);
    for (int i = RD_LAT - 1; i > 0; i--) rdHist[i] = rdHist[i-1];
    rdHist[0] = dmem_rd;

    if (o_wr) begin
      if (expWord.size() == 0) checkOutput("unexpected_wr", o_wr, 1'b0);
      else begin
        e = expWord.pop_front();
        checkOutput("o_data", o_data, e.data);
        checkOutput("o_sof", o_sof, e.sof);
        checkOutput("o_eof", o_eof, e.eof);
        if (e.eof) expFrames++;
      end
      wrCnt++; sofCnt += int'(o_sof); eofCnt += int'(o_eof);
      wrSofLog.push_back(o_sof);
    end

    if (dmem_rd) begin
      checkOutput("rd_while_afull", o_afull, 1'b0);
      if (expAddr.size() == 0) checkOutput("unexpected_rd", dmem_rd, 1'b0);
      else checkOutput("dmem_addr", dmem_addr, expAddr.pop_front());
      addrLog.push_back(int'(dmem_addr));
      cellReads++;
    end

    if (free_wr) begin
      checkOutput("free_while_full", free_full, 1'b0);
      if (freeQ.size() == 0) checkOutput("unexpected_free", free_wr, 1'b0);
      else begin
        p = freeQ.pop_front();
        checkOutput("free_ptr", free_ptr, {1'b0, p[14:0]});
        checkOutput("free_before_words_out", expWord.size(), 0);
        expCells++;
      end
      freeLog.push_back(int'(free_ptr));
      freeCycLog.push_back(cycle);
    end

    if (ptr_ack) begin
      checkOutput("ack_without_rdy", ptr_rdy, 1'b1);
      checkOutput("ack_overlap", freeQ.size(), 0);
      p = ptr_dout;
      freeQ.push_back(p);
      for (int w = 0; w < CELL_WORDS; w++) begin
        a = {p[PTR_AW-1:0], WB'(w)};
        expAddr.push_back(a);
        expWord.push_back('{memWord(a), sofPend && (w == 0), p[15] && (w == CELL_WORDS - 1)});
      end
      sofPend = p[15];
      popReq = 1'b1;
      cellReads = 0;
      ackCycLog.push_back(cycle);
    end
  endtask

  task automatic presentPtr();
    ptr_rdy  = (ptrQ.size() != 0);
    ptr_dout = (ptrQ.size() != 0) ? ptrQ[0] : 16'h0000;
  endtask

  // Drive inputs just after the active edge: pop the FIFO model for an ack
  // taken at that edge and advance the back-pressure schedules.
  task automatic applyStimulus();
    if (popReq) begin
      if (ptrQ.size() != 0) void'(ptrQ.pop_front());
      popReq = 1'b0;
    end
    presentPtr();
    if (stallArm && cellReads == 2) begin
      afullLeft = 5;
      stallArm = 1'b0;
    end
    o_afull = (afullLeft > 0);
    if (afullLeft > 0) afullLeft--;
    if (fullArm && wrCnt == CELL_WORDS) begin
      fullLeft = 10;
      fullArm = 1'b0;
    end
    free_full = (fullLeft > 0);
    if (fullLeft > 0) fullLeft--;
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    applyStimulus();
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (ptrQ.size() != 0 || freeQ.size() != 0 || expWord.size() != 0) begin
      if (n == budget) begin
        checks++; errors++;
        $display("[TB] FAIL drain_timeout: got %0d pointers outstanding expected 0", freeQ.size() + ptrQ.size());
        return;
      end
      tick();
      n++;
    end
    tick();
  endtask

  initial begin
    int base;
    int n;
    rst = 1'b1; ptr_rdy = 1'b0; ptr_dout = '0; o_afull = 1'b0; free_full = 1'b0;
    for (int i = 0; i < RD_LAT; i++) rdHist[i] = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    $display("[TB] single-cell frame 0x8005");
    clearLogs();
    ptrQ.push_back(16'h8005); presentPtr();
    waitDrain(60);
    checkOutput("t1_acks", ackCycLog.size(), 1);
    checkOutput("t1_reads", addrLog.size(), 4);
    for (int i = 0; i < 4; i++) checkOutput("t1_addr", addrLog[i], 20 + i);
    checkOutput("t1_words", wrCnt, 4);
    checkOutput("t1_sof_first", wrSofLog[0], 1'b1);
    checkOutput("t1_eof_count", eofCnt, 1);
    checkOutput("t1_free_ptr", freeLog[0], 16'h0005);
    checkOutput("t1_cell_time", freeCycLog[0] - ackCycLog[0], 8);

    $display("[TB] three-cell frame");
    clearLogs();
    ptrQ.push_back(16'h0010); ptrQ.push_back(16'h0011); ptrQ.push_back(16'h8012);
    presentPtr();
    waitDrain(100);
    checkOutput("t2_words", wrCnt, 12);
    checkOutput("t2_sof_count", sofCnt, 1);
    checkOutput("t2_eof_count", eofCnt, 1);
    checkOutput("t2_free0", freeLog[0], 16'h0010);
    checkOutput("t2_free1", freeLog[1], 16'h0011);
    checkOutput("t2_free2", freeLog[2], 16'h0012);
    checkOutput("t2_period0", ackCycLog[1] - ackCycLog[0], 9);
    checkOutput("t2_period1", ackCycLog[2] - ackCycLog[1], 9);

    $display("[TB] output almost-full stall");
    clearLogs();
    stallArm = 1'b1;
    ptrQ.push_back(16'h8040); presentPtr();
    waitDrain(100);
    checkOutput("t3_words", wrCnt, 4);
    for (int i = 0; i < 4; i++) checkOutput("t3_addr", addrLog[i], 256 + i);
    checkOutput("t3_cell_time", freeCycLog[0] - ackCycLog[0], 13);

    $display("[TB] free FIFO full");
    clearLogs();
    fullArm = 1'b1;
    ptrQ.push_back(16'h8041); ptrQ.push_back(16'h8042); presentPtr();
    waitDrain(120);
    checkOutput("t4_free_delay", freeCycLog[0] - ackCycLog[0], 18);
    checkOutput("t4_next_ack", ackCycLog[1] - freeCycLog[0], 1);
    checkOutput("t4_free0", freeLog[0], 16'h0041);
    checkOutput("t4_free1", freeLog[1], 16'h0042);

    $display("[TB] reset during second cell");
    clearLogs();
    ptrQ.push_back(16'h0030); ptrQ.push_back(16'h0031); ptrQ.push_back(16'h8032);
    presentPtr();
    n = 0;
    while (ackCycLog.size() < 2 && n < 60) begin tick(); n++; end
    checkOutput("t5_second_ack", ackCycLog.size(), 2);
    tick(); tick();
    rst = 1'b1;
    ptrQ.delete(); popReq = 1'b0; presentPtr();
    tick(); tick();
    rst = 1'b0;
    tick();
    clearLogs();
    ptrQ.push_back(16'h8020); presentPtr();
    waitDrain(60);
    checkOutput("t5_words", wrCnt, 4);
    checkOutput("t5_sof_first", wrSofLog[0], 1'b1);
    checkOutput("t5_eof_count", eofCnt, 1);
    checkOutput("t5_free", freeLog[0], 16'h0020);
    checkOutput("t5_free_count", freeLog.size(), 1);

`ifdef SWITCH_OQ_STAT_EN
    $display("[TB] statistics counters");
    rst = 1'b1; presentPtr();
    tick();
    rst = 1'b0;
    tick();
    clearLogs();
    ptrQ.push_back(16'h8050); ptrQ.push_back(16'h0051);
    ptrQ.push_back(16'h0052); ptrQ.push_back(16'h8053);
    presentPtr();
    waitDrain(150);
    checkOutput("stat_frames", stat_frames, 32'd2);
    checkOutput("stat_cells", stat_cells, 32'd4);
    checkOutput("stat_frames_model", stat_frames, expFrames);
    checkOutput("stat_cells_model", stat_cells, expCells);
`endif

    base = 0;
    checkOutput("final_words_left", expWord.size(), base);
    checkOutput("final_ptrs_left", freeQ.size(), base);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
